uart_rx: RTL and testbench

- Serial-to-parallel UART receiver that sits directly downstream of the UART transmitter on the SoC serial link.
- Deserialises frames of the form: start bit (0), WIDTH data bits LSB first, one stop bit (1).
- Presents each received word with a valid/acknowledge handshake toward the APB/UART register interface.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 40 ++++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receive path.
//   - FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH)
//   - UART_WIDTH: default number of data bits per frame
//   - LINE_IDLE:  idle (mark) level of the serial line
package uart_pkg;

    localparam int   UART_WIDTH = 32;
    localparam logic LINE_IDLE  = 1'b1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line gives no false edge on
// reset release.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   d_in    in   asynchronous input
//   d_sync  out  input re-timed to clk (two-cycle delay)
module uart_sync
    import uart_pkg::*;
#(
    parameter logic RST_VAL = LINE_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver.
// Frame: start bit (0), WIDTH data bits LSB first, one stop bit (1).
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   rx_in       in   serial line, idle high, asynchronous to clk
//   rd_en       in   consumer acknowledge, pops the held word
//   p_data      out  received word, stable while data_valid=1
//   data_valid  out  held word available (level until acknowledged)
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: word dropped, previous still held
//   busy        out  FSM not in IDLE
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | counting to mid start bit to reject glitches
// DATA      | sampling WIDTH data bits, one per bit period
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = UART_WIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] p_data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int PW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(WIDTH + 1);

    localparam logic [PW-1:0] PH_HALF  = PW'(HALF);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             phase_end;
    logic             word_done;

    uart_sync #(.RST_VAL(LINE_IDLE)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_in   (rx_in),
        .d_sync (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        p_data_d    = p_data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        word_done   = 1'b0;
        phase_end   = (phase_q == PH_LAST);

        case (state_q)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    // With no half-bit to wait out, the start bit is accepted at once.
                    state_d   = (HALF == 0) ? DATA : START;
                end
            end
            START: begin
                if (phase_q == PH_HALF) begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = (rx_s == LINE_IDLE) ? IDLE : DATA;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            DATA: begin
                if (phase_end) begin
                    // Right shift: the first bit received ends up in bit 0.
                    shift_d   = {rx_s, shift_q[WIDTH-1:1]};
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            STOP: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (rx_s == LINE_IDLE) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An acknowledge coinciding with a completion frees the slot for the new word.
        if (word_done) begin
            if (!valid_q || rd_en) begin
                p_data_d = shift_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rd_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            p_data_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            p_data_q    <= p_data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a one-clock-per-bit instance and a 16-clock-per-bit
// instance, both WIDTH=8, driven from shared stimulus tasks.
module tb_uart_rx;

    localparam int W  = 8;
    localparam int CS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic         line_f = 1'b1, rd_f = 1'b0;
    logic [W-1:0] pd_f;
    logic         dv_f, fe_f, ov_f, busy_f;

    logic         line_s = 1'b1, rd_s = 1'b0;
    logic [W-1:0] pd_s;
    logic         dv_s, fe_s, ov_s, busy_s;

    uart_rx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_fast (
        .clk(clk), .rst(rst_n), .rx_in(line_f), .rd_en(rd_f),
        .p_data(pd_f), .data_valid(dv_f), .frame_err(fe_f),
        .overrun(ov_f), .busy(busy_f)
    );

    uart_rx #(.WIDTH(W), .CLKS_PER_BIT(CS)) u_slow (
        .clk(clk), .rst(rst_n), .rx_in(line_s), .rd_en(rd_s),
        .p_data(pd_s), .data_valid(dv_s), .frame_err(fe_s),
        .overrun(ov_s), .busy(busy_s)
    );

    int total = 0;
    int bad   = 0;

    // Edge counter and pulse counters, sampled 2 time units after each rising edge.
    int   cyc = 0;
    int   fe_cnt_f = 0, ov_cnt_f = 0, fe_cnt_s = 0, ov_cnt_s = 0, busy_cnt_s = 0;
    int   rise_cyc_f = -1;
    logic dv_prev_f = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            fe_cnt_f   += int'(fe_f);
            ov_cnt_f   += int'(ov_f);
            fe_cnt_s   += int'(fe_s);
            ov_cnt_s   += int'(ov_s);
            busy_cnt_s += int'(busy_s);
            if (dv_f && !dv_prev_f) rise_cyc_f = cyc;
            dv_prev_f = dv_f;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_f(input logic [W-1:0] d, input logic stop, input int gap);
        line_f = 1'b0;
        tick(1);
        for (int i = 0; i < W; i++) begin
            line_f = d[i];
            tick(1);
        end
        line_f = stop;
        tick(1);
        line_f = 1'b1;
        tick(gap);
    endtask

    task automatic frame_s(input logic [W-1:0] d, input logic stop, input int gap);
        line_s = 1'b0;
        tick(CS);
        for (int i = 0; i < W; i++) begin
            line_s = d[i];
            tick(CS);
        end
        line_s = stop;
        tick(CS);
        line_s = 1'b1;
        tick(gap);
    endtask

    task automatic ack_f();
        rd_f = 1'b1;
        tick(1);
        rd_f = 1'b0;
    endtask

    task automatic ack_s();
        rd_s = 1'b1;
        tick(1);
        rd_s = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack;
        logic [7:0] exp_pd;
        logic       exp_dv;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int           k, fe0, ov0, b0;
        logic [W-1:0] d, m_pd;
        logic         m_dv, ack, good;
        int           exp_fe, exp_ov;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 0};
        vecs[2] = '{8'hC3, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1, 0};
        vecs[5] = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 0, 0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'h12, 1'b1, 1, 0};
        vecs[7] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 0, 0};

        // Reset values
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_pdata_f", 32'(pd_f), 32'h0);
        check("rst_dv_f",    32'(dv_f), 32'h0);
        check("rst_fe_f",    32'(fe_f), 32'h0);
        check("rst_ov_f",    32'(ov_f), 32'h0);
        check("rst_busy_f",  32'(busy_f), 32'h0);
        check("rst_dv_s",    32'(dv_s), 32'h0);
        check("rst_busy_s",  32'(busy_s), 32'h0);
        rst_n = 1'b1;
        tick(4);
        check("no_false_start", 32'(busy_f), 32'h0);

        // Test 1: latency and data for 0xA5
        fe0 = fe_cnt_f; ov0 = ov_cnt_f;
        rise_cyc_f = -1;
        k = cyc + 1;
        frame_f(8'hA5, 1'b1, 1);
        tick(3);
        check("t1_latency", 32'(rise_cyc_f), 32'(k + 11));
        check("t1_pdata",   32'(pd_f), 32'hA5);
        check("t1_dv",      32'(dv_f), 32'h1);
        check("t1_fe",      32'(fe_cnt_f - fe0), 32'h0);
        check("t1_ov",      32'(ov_cnt_f - ov0), 32'h0);
        ack_f();
        tick(1);
        check("t1_ack_dv",    32'(dv_f), 32'h0);
        check("t1_ack_pdata", 32'(pd_f), 32'hA5);

        // Test 3: back-to-back, never acknowledged
        ov0 = ov_cnt_f;
        frame_f(8'h3C, 1'b1, 0);
        frame_f(8'hC3, 1'b1, 2);
        tick(3);
        check("t3_pdata", 32'(pd_f), 32'h3C);
        check("t3_dv",    32'(dv_f), 32'h1);
        check("t3_ov",    32'(ov_cnt_f - ov0), 32'h1);
        ack_f();
        tick(2);

        // Test 4: acknowledge exactly on the second frame's completion edge
        ov0 = ov_cnt_f;
        k = cyc + 1;
        fork
            begin
                frame_f(8'h3C, 1'b1, 0);
                frame_f(8'hC3, 1'b1, 2);
            end
            begin
                tick(k + 20 - cyc);
                rd_f = 1'b1;
                tick(1);
                rd_f = 1'b0;
            end
        join
        tick(3);
        check("t4_pdata", 32'(pd_f), 32'hC3);
        check("t4_dv",    32'(dv_f), 32'h1);
        check("t4_ov",    32'(ov_cnt_f - ov0), 32'h0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ack) ack_f();
            fe0 = fe_cnt_f; ov0 = ov_cnt_f;
            frame_f(vecs[i].data, vecs[i].stop, 3);
            tick(2);
            check($sformatf("vec%0d_pdata", i), 32'(pd_f), 32'(vecs[i].exp_pd));
            check($sformatf("vec%0d_dv", i),    32'(dv_f), 32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_fe", i),    32'(fe_cnt_f - fe0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_ov", i),    32'(ov_cnt_f - ov0), 32'(vecs[i].exp_ov));
        end

        // Test 5: framing error followed by a break
        ack_f();
        fe0 = fe_cnt_f;
        frame_f(8'hFF, 1'b0, 0);
        line_f = 1'b0;
        tick(20);
        check("t5_fe",   32'(fe_cnt_f - fe0), 32'h1);
        check("t5_dv",   32'(dv_f), 32'h0);
        check("t5_wait", 32'(busy_f), 32'h1);
        line_f = 1'b1;
        tick(4);
        check("t5_idle", 32'(busy_f), 32'h0);
        frame_f(8'h12, 1'b1, 3);
        tick(2);
        check("t5_pdata", 32'(pd_f), 32'h12);
        check("t5_dv2",   32'(dv_f), 32'h1);
        check("t5_fe2",   32'(fe_cnt_f - fe0), 32'h1);
        ack_f();

        // Test 6: reset during bit 4 of a frame
        d = 8'hE7;
        line_f = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            line_f = d[i];
            tick(1);
        end
        line_f = d[4];
        rst_n = 1'b0;
        line_f = 1'b1;
        tick(3);
        check("t6_rst_pdata", 32'(pd_f), 32'h0);
        check("t6_rst_busy",  32'(busy_f), 32'h0);
        rst_n = 1'b1;
        fe0 = fe_cnt_f; ov0 = ov_cnt_f;
        tick(20);
        check("t6_dv",   32'(dv_f), 32'h0);
        check("t6_busy", 32'(busy_f), 32'h0);
        check("t6_fe",   32'(fe_cnt_f - fe0), 32'h0);
        frame_f(8'h5A, 1'b1, 3);
        tick(2);
        check("t6_pdata", 32'(pd_f), 32'h5A);
        check("t6_dv2",   32'(dv_f), 32'h1);
        ack_f();
        tick(1);

        // Randomised frames against a word-holding model
        m_pd = 8'h5A;
        m_dv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d    = W'($urandom);
            ack  = 1'($urandom_range(0, 1));
            good = ($urandom_range(0, 7) != 0);
            if (ack) begin
                ack_f();
                m_dv = 1'b0;
            end
            fe0 = fe_cnt_f; ov0 = ov_cnt_f;
            frame_f(d, good, 3);
            tick(2);
            exp_fe = good ? 0 : 1;
            exp_ov = 0;
            if (good) begin
                if (m_dv) begin
                    exp_ov = 1;
                end else begin
                    m_pd = d;
                    m_dv = 1'b1;
                end
            end
            check($sformatf("rnd%0d_pdata", i), 32'(pd_f), 32'(m_pd));
            check($sformatf("rnd%0d_dv", i),    32'(dv_f), 32'(m_dv));
            check($sformatf("rnd%0d_fe", i),    32'(fe_cnt_f - fe0), 32'(exp_fe));
            check($sformatf("rnd%0d_ov", i),    32'(ov_cnt_f - ov0), 32'(exp_ov));
        end

        // Test 2: short glitch on the 16-clock instance
        b0 = busy_cnt_s; fe0 = fe_cnt_s;
        line_s = 1'b0;
        tick(3);
        line_s = 1'b1;
        tick(40);
        b0 = busy_cnt_s - b0;
        check("t2_busy_len", 32'(b0 >= 6 && b0 <= 12), 32'h1);
        check("t2_busy_end", 32'(busy_s), 32'h0);
        check("t2_dv",       32'(dv_s), 32'h0);
        check("t2_fe",       32'(fe_cnt_s - fe0), 32'h0);

        // Frames on the 16-clock instance
        for (int i = 0; i < 3; i++) begin
            d = W'($urandom);
            ov0 = ov_cnt_s;
            frame_s(d, 1'b1, CS);
            tick(4);
            check($sformatf("slow%0d_pdata", i), 32'(pd_s), 32'(d));
            check($sformatf("slow%0d_dv", i),    32'(dv_s), 32'h1);
            check($sformatf("slow%0d_ov", i),    32'(ov_cnt_s - ov0), 32'h0);
            ack_s();
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
